// File: rtl/serial_cmp_pkg.sv
// Shared types and sizing helpers for the bit-serial magnitude comparator.
//   state_e  : controller state (binary, 2 bits)
//   calc_cw  : width of the cycles counter for a given operand width
//   calc_iw  : width of the bit-index register for a given operand width
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Holds 0..WIDTH, since an equal compare uses WIDTH cycles.
  function automatic int calc_cw(input int w);
    return $clog2(w) + 1;
  endfunction

  // WIDTH=1 still needs a 1-bit index register (fixed at 0).
  function automatic int calc_iw(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/cmp_bit_cell.sv
// Purely combinational 1-bit comparator cell.
//   a, b : operand bits
//   g    : a > b
//   l    : a < b
//   e    : a == b
module cmp_bit_cell (
  input  logic a,
  input  logic b,
  output logic g,
  output logic l,
  output logic e
);

  assign g = a & ~b;
  assign l = ~a & b;
  assign e = ~(a ^ b);

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Bit-serial, MSB-first unsigned magnitude comparator. A single 1-bit cell
// is reused each cycle; the walk stops at the first differing bit.
//   clk, rst_n : clock, async active-low reset
//   start      : request, accepted only in IDLE
//   a_in, b_in : operands, captured on accepted start
//   busy       : high in COMPARE and DONE
//   done       : one-cycle pulse when gt/lt/eq/cycles are valid
//   gt, lt, eq : registered result, held until the next accepted start
//   cycles     : COMPARE cycles used by the last operation
module serial_cmp_ctrl
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WIDTH-1:0]       a_in,
  input  logic [WIDTH-1:0]       b_in,
  output logic                   busy,
  output logic                   done,
  output logic                   gt,
  output logic                   lt,
  output logic                   eq,
  output logic [$clog2(WIDTH):0] cycles
);

  localparam int CW = calc_cw(WIDTH);
  localparam int IW = calc_iw(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
  logic [CW-1:0]    cyc_q, cyc_d;

  logic cell_g, cell_l, cell_e;
  logic last_bit;

  cmp_bit_cell u_cell (
    .a (a_q[idx_q]),
    .b (b_q[idx_q]),
    .g (cell_g),
    .l (cell_l),
    .e (cell_e)
  );

  assign last_bit = (idx_q == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = COMPARE;
      COMPARE: if (cell_g || cell_l || last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      COMPARE: busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next-state. cell_e is implied by !g && !l, so the eq decision
  // only needs the index check.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    idx_d = idx_q;
    gt_d  = gt_q;
    lt_d  = lt_q;
    eq_d  = eq_q;
    cyc_d = cyc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d   = a_in;
          b_d   = b_in;
          idx_d = IW'(WIDTH - 1);
          gt_d  = 1'b0;
          lt_d  = 1'b0;
          eq_d  = 1'b0;
          cyc_d = '0;
        end
      end
      COMPARE: begin
        cyc_d = cyc_q + CW'(1);
        if (cell_g)        gt_d  = 1'b1;
        else if (cell_l)   lt_d  = 1'b1;
        else if (last_bit) eq_d  = cell_e;
        else               idx_d = idx_q - IW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      idx_q <= '0;
      gt_q  <= 1'b0;
      lt_q  <= 1'b0;
      eq_q  <= 1'b0;
      cyc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      idx_q <= idx_d;
      gt_q  <= gt_d;
      lt_q  <= lt_d;
      eq_q  <= eq_d;
      cyc_q <= cyc_d;
    end
  end

  assign gt     = gt_q;
  assign lt     = lt_q;
  assign eq     = eq_q;
  assign cycles = cyc_q;

endmodule
